// File: rtl/nn_pkg.sv
// nn_pkg: shared state encoding and index-width helpers for the layer sequencer.
package nn_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, CLEAR, MAC, CAPTURE, OUTPUT, DONE} seq_state_t;
    function automatic int width_of(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    function automatic int addr_w(input int size, input int depth);
        return width_of(size * depth);
    endfunction
    function automatic int layer_w(input int depth);
        return width_of(depth);
    endfunction
    function automatic int node_w(input int size);
        return width_of(size);
    endfunction
endpackage

// File: rtl/act_buffer.sv
// act_buffer: activation vector storage with serial load, parallel capture and indexed read.
module act_buffer #(
    parameter int SIZE = 4,
    parameter int BIT_SIZE = 8,
    parameter int IDX_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [BIT_SIZE-1:0]      wr_data,
    input  logic                     ld_en,
    input  logic [SIZE*BIT_SIZE-1:0] ld_data,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [BIT_SIZE-1:0]      rd_data
);
    logic [SIZE-1:0][BIT_SIZE-1:0] mem;
    always_ff @(posedge clk or posedge rst)
        if (rst) mem <= '0;
        else if (clr) mem <= '0;
        else if (ld_en) mem <= ld_data;
        else if (wr_en) mem[wr_idx] <= wr_data;
    assign rd_data = mem[rd_idx];
endmodule

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: runs one forward pass, loading inputs, sequencing per-layer MACs
// with one-cycle-ahead weight prefetch, feeding results back and streaming the final vector.
module nn_layer_sequencer import nn_pkg::*; #(
    parameter int LAYER_SIZE = 4,
    parameter int LAYER_DEPTH = 3,
    parameter int BIT_SIZE = 8,
    localparam int ADDR_W = addr_w(LAYER_SIZE, LAYER_DEPTH),
    localparam int LAYER_W = layer_w(LAYER_DEPTH),
    localparam int NODE_W = node_w(LAYER_SIZE)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [BIT_SIZE-1:0]            in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [BIT_SIZE-1:0]            out_data,
    output logic                           out_last,
    output logic                           w_rd_en,
    output logic [ADDR_W-1:0]              w_addr,
    input  logic [LAYER_SIZE*BIT_SIZE-1:0] w_rdata,
    output logic                           dp_clr,
    output logic                           dp_en,
    output logic [BIT_SIZE-1:0]            dp_x,
    output logic [LAYER_SIZE*BIT_SIZE-1:0] dp_w,
    input  logic [LAYER_SIZE*BIT_SIZE-1:0] dp_y,
    output logic [LAYER_W-1:0]             layer,
    output logic [NODE_W-1:0]              node
);
    localparam logic [NODE_W-1:0] NODE_LAST = NODE_W'(LAYER_SIZE - 1);
    localparam logic [LAYER_W-1:0] LAYER_LAST = LAYER_W'(LAYER_DEPTH - 1);
    seq_state_t state, state_nx;
    logic [LAYER_W-1:0] layer_nx;
    logic [NODE_W-1:0] node_nx;
    logic [ADDR_W-1:0] base;
    logic [BIT_SIZE-1:0] rd_data;
    logic last_node;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            layer <= '0;
            node <= '0;
        end else begin
            state <= state_nx;
            layer <= layer_nx;
            node <= node_nx;
        end
    assign last_node = node == NODE_LAST;
    always_comb begin
        state_nx = state;
        layer_nx = layer;
        node_nx = node;
        case (state)
            IDLE: if (start) begin
                state_nx = LOAD;
                layer_nx = '0;
                node_nx = '0;
            end
            LOAD: if (in_valid) begin
                node_nx = last_node ? '0 : node + 1'b1;
                state_nx = last_node ? CLEAR : LOAD;
            end
            CLEAR: state_nx = MAC;
            MAC: begin
                node_nx = last_node ? '0 : node + 1'b1;
                state_nx = last_node ? CAPTURE : MAC;
            end
            CAPTURE: begin
                state_nx = layer == LAYER_LAST ? OUTPUT : CLEAR;
                layer_nx = layer == LAYER_LAST ? layer : layer + 1'b1;
                node_nx = '0;
            end
            OUTPUT: if (out_ready) begin
                state_nx = last_node ? DONE : OUTPUT;
                node_nx = last_node ? node : node + 1'b1;
            end
            DONE: begin
                state_nx = IDLE;
                layer_nx = '0;
                node_nx = '0;
            end
            default: state_nx = IDLE;
        endcase
    end
    // Row address for node 0 of the current layer; MAC prefetches the row for node+1.
    assign base = ADDR_W'(layer) * ADDR_W'(LAYER_SIZE);
    assign busy = state != IDLE;
    assign done = state == DONE;
    assign in_ready = state == LOAD;
    assign out_valid = state == OUTPUT;
    assign out_last = out_valid && last_node;
    assign out_data = out_valid ? rd_data : '0;
    assign dp_clr = state == CLEAR;
    assign dp_en = state == MAC;
    assign dp_x = dp_en ? rd_data : '0;
    assign dp_w = w_rdata;
    assign w_rd_en = dp_clr || (dp_en && !last_node);
    assign w_addr = dp_clr ? base : w_rd_en ? base + ADDR_W'(node) + 1'b1 : '0;
    act_buffer #(.SIZE(LAYER_SIZE), .BIT_SIZE(BIT_SIZE), .IDX_W(NODE_W)) u_buf (
        .clk(clk),
        .rst(rst),
        .clr(state == IDLE && start),
        .wr_en(in_ready && in_valid),
        .wr_idx(node),
        .wr_data(in_data),
        .ld_en(state == CAPTURE),
        .ld_data(dp_y),
        .rd_idx(node),
        .rd_data(rd_data)
    );
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb_nn_layer_sequencer: directed scenarios against a behavioural weight ROM and MAC datapath.
module tb_nn_layer_sequencer;
    logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
    logic [7:0] in_data = 0;
    logic busy, done, in_ready, out_valid, out_last, w_rd_en, dp_clr, dp_en;
    logic [7:0] out_data, dp_x;
    logic [2:0] w_addr;
    logic [31:0] w_rdata, dp_w, dp_y;
    logic [0:0] layer;
    logic [1:0] node;
    int checks = 0, passed = 0, n_clr = 0, n_done = 0;
    logic [2:0] addrq[$];
    logic [8:0] outq[$];
    logic [15:0] acc[4];
    bit scaled = 0;

    nn_layer_sequencer #(.LAYER_SIZE(4), .LAYER_DEPTH(2), .BIT_SIZE(8)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
        .dp_clr(dp_clr), .dp_en(dp_en), .dp_x(dp_x), .dp_w(dp_w), .dp_y(dp_y),
        .layer(layer), .node(node)
    );

    always #5 clk = ~clk;

    // identity: all layers I; scaled: layer 0 = 2*I, layer 1 = reversal permutation
    function automatic logic [31:0] rom(input logic [2:0] a);
        logic [31:0] r = '0;
        for (int j = 0; j < 4; j++)
            if (!scaled) r[j*8+:8] = (a[1:0] == 2'(j)) ? 8'd1 : 8'd0;
            else if (!a[2]) r[j*8+:8] = (a[1:0] == 2'(j)) ? 8'd2 : 8'd0;
            else r[j*8+:8] = (a[1:0] == 2'(3 - j)) ? 8'd1 : 8'd0;
        return r;
    endfunction

    always @(posedge clk) begin
        if (w_rd_en) w_rdata <= rom(w_addr);
        for (int j = 0; j < 4; j++)
            if (dp_clr) acc[j] <= '0;
            else if (dp_en) acc[j] <= acc[j] + 16'(dp_x) * 16'(dp_w[j*8+:8]);
    end
    always_comb for (int j = 0; j < 4; j++) dp_y[j*8+:8] = acc[j][7:0];

    always @(negedge clk) begin
        if (w_rd_en) addrq.push_back(w_addr);
        if (dp_clr) n_clr++;
        if (done) n_done++;
        if (out_valid && out_ready) outq.push_back({out_last, out_data});
    end

    task automatic run_pass(input logic [31:0] vec, input bit gaps, input bit bp, input bit noise, output int lat);
        int cyc;
        logic [8:0] held;
        bit stalled;
        addrq.delete(); outq.delete(); n_clr = 0; n_done = 0;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        for (int k = 0; k < 4; k++) begin
            if (gaps) begin in_valid = 0; repeat (2) @(posedge clk); #1; end
            in_valid = 1; in_data = vec[k*8+:8];
            @(posedge clk); #1;
        end
        in_valid = noise; start = noise; in_data = 8'hff;
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        start = 0; in_valid = 0;
        if (lat >= 100) begin checks++; $display("FAIL compute_timeout: out_valid=%b required=1", out_valid); end
        cyc = 0; stalled = 0; held = '0;
        while (!done && cyc < 100) begin
            out_ready = bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            if (stalled && out_valid) begin
                checks++;
                if ({out_last, out_data} !== held) $display("FAIL stall_hold: got %h required %h", {out_last, out_data}, held);
                else passed++;
            end
            stalled = out_valid && !out_ready; held = {out_last, out_data};
            @(posedge clk); #1; cyc++;
        end
        out_ready = 0;
        if (cyc >= 100) begin checks++; $display("FAIL output_timeout: done=%b required=1", done); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bit seen = 0;
        repeat (2) @(posedge clk); #1;
        checks++;
        if ({busy, done, in_ready, out_valid, out_last, w_rd_en, dp_clr, dp_en} !== 8'h00)
            $display("FAIL reset_ctrl: got %b required 00000000", {busy, done, in_ready, out_valid, out_last, w_rd_en, dp_clr, dp_en});
        else passed++;
        checks++;
        if ({out_data, dp_x, w_addr, layer, node} !== 22'h0)
            $display("FAIL reset_data: got %h required 0", {out_data, dp_x, w_addr, layer, node});
        else passed++;
        rst = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (busy || in_ready || out_valid || w_rd_en) seen = 1;
        end
        checks++;
        if (seen !== 1'b0) $display("FAIL idle_quiet: activity=%b required 0", seen);
        else passed++;
    endtask

    task automatic test_addresses();
        int lat;
        logic [7:0] exp[4] = '{8, 6, 4, 2};
        scaled = 1;
        run_pass({8'd4, 8'd3, 8'd2, 8'd1}, 0, 0, 0, lat);
        checks++;
        if (addrq.size() !== 8) $display("FAIL addr_count: got %0d required 8", addrq.size());
        else passed++;
        for (int i = 0; i < 8 && i < addrq.size(); i++) begin
            checks++;
            if (addrq[i] !== 3'(i)) $display("FAIL addr_seq[%0d]: got %0d required %0d", i, addrq[i], i);
            else passed++;
        end
        checks++;
        if (n_clr !== 2) $display("FAIL clr_count: got %0d required 2", n_clr);
        else passed++;
        checks++;
        if (lat !== 12) $display("FAIL latency: got %0d required 12", lat);
        else passed++;
        for (int k = 0; k < 4 && k < outq.size(); k++) begin
            checks++;
            if (outq[k] !== {k == 3, exp[k]}) $display("FAIL addr_out[%0d]: got %h required %h", k, outq[k], {k == 3, exp[k]});
            else passed++;
        end
    endtask

    task automatic test_identity();
        int lat;
        logic [7:0] exp[4] = '{5, 6, 7, 8};
        scaled = 0;
        run_pass({8'd8, 8'd7, 8'd6, 8'd5}, 0, 0, 0, lat);
        checks++;
        if (outq.size() !== 4) $display("FAIL ident_count: got %0d required 4", outq.size());
        else passed++;
        for (int k = 0; k < 4 && k < outq.size(); k++) begin
            checks++;
            if (outq[k] !== {k == 3, exp[k]}) $display("FAIL ident_out[%0d]: got %h required %h", k, outq[k], {k == 3, exp[k]});
            else passed++;
        end
        checks++;
        if (n_done !== 1) $display("FAIL done_pulses: got %0d required 1", n_done);
        else passed++;
        checks++;
        if ({busy, done} !== 2'b00) $display("FAIL after_done: busy,done=%b required 00", {busy, done});
        else passed++;
    endtask

    task automatic test_backpressure();
        int lat;
        logic [7:0] exp[4] = '{80, 60, 40, 20};
        scaled = 1;
        run_pass({8'd40, 8'd30, 8'd20, 8'd10}, 1, 1, 0, lat);
        checks++;
        if (outq.size() !== 4) $display("FAIL bp_count: got %0d required 4", outq.size());
        else passed++;
        for (int k = 0; k < 4 && k < outq.size(); k++) begin
            checks++;
            if (outq[k] !== {k == 3, exp[k]}) $display("FAIL bp_out[%0d]: got %h required %h", k, outq[k], {k == 3, exp[k]});
            else passed++;
        end
    endtask

    task automatic test_abort();
        int cyc = 0, lat;
        logic [7:0] exp[4] = '{12, 14, 16, 18};
        scaled = 1;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1; in_data = 8'(k + 1);
            @(posedge clk); #1;
        end
        in_valid = 0;
        while (!(layer == 1'b1 && dp_en) && cyc < 50) begin @(posedge clk); #1; cyc++; end
        checks++;
        if (cyc >= 50) $display("FAIL abort_reach_mac: layer=%0d dp_en=%b required 1,1", layer, dp_en);
        else passed++;
        rst = 1; #1;
        checks++;
        if ({busy, done, in_ready, out_valid, w_rd_en, dp_clr, dp_en, layer, node, dp_x, w_addr} !== 21'h0)
            $display("FAIL abort_outputs: got %h required 0", {busy, done, in_ready, out_valid, w_rd_en, dp_clr, dp_en, layer, node, dp_x, w_addr});
        else passed++;
        @(posedge clk); #1 rst = 0;
        run_pass({8'd6, 8'd7, 8'd8, 8'd9}, 0, 0, 0, lat);
        for (int k = 0; k < 4 && k < outq.size(); k++) begin
            checks++;
            if (outq[k] !== {k == 3, exp[k]}) $display("FAIL abort_out[%0d]: got %h required %h", k, outq[k], {k == 3, exp[k]});
            else passed++;
        end
        checks++;
        if (n_done !== 1) $display("FAIL abort_done: got %0d required 1", n_done);
        else passed++;
    endtask

    task automatic test_spurious();
        int lat;
        logic [7:0] exp[4] = '{18, 14, 10, 6};
        scaled = 1;
        run_pass({8'd9, 8'd7, 8'd5, 8'd3}, 0, 0, 1, lat);
        checks++;
        if (lat !== 12) $display("FAIL spur_latency: got %0d required 12", lat);
        else passed++;
        checks++;
        if (outq.size() !== 4) $display("FAIL spur_count: got %0d required 4", outq.size());
        else passed++;
        for (int k = 0; k < 4 && k < outq.size(); k++) begin
            checks++;
            if (outq[k] !== {k == 3, exp[k]}) $display("FAIL spur_out[%0d]: got %h required %h", k, outq[k], {k == 3, exp[k]});
            else passed++;
        end
        checks++;
        if (busy !== 1'b0) $display("FAIL spur_idle: busy=%b required 0", busy);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_addresses();
        test_identity();
        test_backpressure();
        test_abort();
        test_spurious();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/nn_layer_sequencer.md
# nn_layer_sequencer

Controller that runs one complete forward pass through the layer datapath. It accepts an input activation vector and fetches each layer's weight columns from the weight ROM/RAM. It drives the serial MAC datapath one node per cycle, feeds each layer's outputs back as the next layer's inputs, and streams the final vector out. It sits between the host-side stream interface and the neuron array, and it owns all layer/node indexing.

## Interface
Parameters:
- LAYER_SIZE, 4: neurons per layer; also the length of the input and output vectors.
- LAYER_DEPTH, 3: number of layers evaluated per pass.
- BIT_SIZE, 8: activation/weight word width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a pass; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse after the last output beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  high only in LOAD.
- in_data  in  BIT_SIZE  input activation; beat k is element k.
- out_valid  out  1  output beat valid.
- out_ready  in  1  sink accepts.
- out_data  out  BIT_SIZE  output element.
- out_last  out  1  high on beat LAYER_SIZE-1.
- w_rd_en  out  1  weight read strobe.
- w_addr  out  $clog2(LAYER_DEPTH*LAYER_SIZE)  weight row address.
- w_rdata  in  LAYER_SIZE*BIT_SIZE  weight row; valid exactly 1 cycle after w_rd_en.
- dp_clr  out  1  clear datapath accumulators.
- dp_en  out  1  MAC enable.
- dp_x  out  BIT_SIZE  serial activation to the datapath.
- dp_w  out  LAYER_SIZE*BIT_SIZE  weight row to the datapath (w_rdata passed through).
- dp_y  in  LAYER_SIZE*BIT_SIZE  activated layer outputs; valid the cycle after the last dp_en.
- layer  out  $clog2(LAYER_DEPTH)  current layer index.
- node  out  $clog2(LAYER_SIZE)  current node index.

## Operation
- FSM states: IDLE, LOAD, CLEAR, MAC, CAPTURE, OUTPUT, DONE.
- IDLE: waits for start. start=1 moves to LOAD, with layer=0 and node=0.
- LOAD: each in_valid&in_ready beat writes buf[node] and increments node. On the beat where node=LAYER_SIZE-1 the FSM moves to CLEAR and node returns to 0.
- CLEAR: dp_clr=1, w_rd_en=1, w_addr=layer*LAYER_SIZE+0. Next state is MAC.
- MAC: lasts LAYER_SIZE cycles, node=0..LAYER_SIZE-1.
  - dp_en=1, dp_x=buf[node], dp_w=w_rdata.
  - While node<LAYER_SIZE-1: w_rd_en=1 and w_addr=layer*LAYER_SIZE+node+1 (prefetch for the next node).
  - After node=LAYER_SIZE-1 the FSM moves to CAPTURE.
- CAPTURE: buf <= dp_y, all LAYER_SIZE elements in parallel.
  - If layer==LAYER_DEPTH-1: go to OUTPUT with node=0.
  - Else: layer+1, go to CLEAR.
- OUTPUT: out_valid=1, out_data=buf[node], out_last=(node==LAYER_SIZE-1). Each out_valid&out_ready beat increments node. The last accepted beat moves the FSM to DONE.
- DONE: done=1 for one cycle, then IDLE with layer=0 and node=0.
- Address arithmetic is unsigned, computed at full w_addr width, and never wraps within a pass.
- start is ignored while busy. in_valid outside LOAD is ignored.

## Timing
- Reset values: state=IDLE, layer=0, node=0, buf=0. busy, done, in_ready, out_valid, out_last, w_rd_en, dp_clr and dp_en are all 0. out_data=0, dp_x=0, w_addr=0.
- Reset asserted mid-pass aborts immediately. There is no done pulse, and buf contents are discarded (cleared).
- All control outputs are registered-state decodes. dp_w is a combinational pass-through of w_rdata.
- Compute latency, from the cycle after the last LOAD beat to the first out_valid: LAYER_DEPTH*(LAYER_SIZE+2) cycles.
- OUTPUT holds out_data and out_last stable while out_valid&!out_ready.
- LOAD stalls indefinitely on in_valid=0. OUTPUT stalls indefinitely on out_ready=0.

## Structure
- Package nn_pkg holds:
  - the state enum (seq_state_t);
  - width helpers: ADDR_W = $clog2(LAYER_DEPTH*LAYER_SIZE), LAYER_W, NODE_W.
- One sub-module: act_buffer. It is LAYER_SIZE×BIT_SIZE storage with a serial write port (LOAD), a parallel write port (CAPTURE), an indexed read port and a clear.
- The FSM and counters stay in nn_layer_sequencer.

## Test plan
All scenarios use LAYER_SIZE=4, LAYER_DEPTH=2, BIT_SIZE=8.
- Reset then idle: no start for 20 cycles -> busy, in_ready and out_valid stay 0; no w_rd_en.
- Address sequence: start, inputs 1,2,3,4 -> w_addr sequence is 0,1,2,3 then 4,5,6,7. dp_clr fires exactly twice. The first out_valid appears 12 cycles after the last input beat.
- Datapath model with identity weights and identity activation: inputs 5,6,7,8 -> outputs 5,6,7,8 with out_last on the 4th beat, then a single done pulse.
- Backpressure: out_ready toggling 1,0,0,1… -> no beats lost or duplicated; out_data stable while stalled. Input in_valid gaps -> LOAD waits and buf is correct.
- Abort: assert rst during MAC of layer 1 -> all outputs return to reset values the same cycle. A subsequent normal pass produces correct results.
- Spurious start and in_valid while busy -> ignored; the result matches the undisturbed pass.
